regfile_arbiter: RTL

Two-requester arbiter and sequencer in front of `registerFile`; it shares that block's single write port and two read ports between the execute unit (requester 0) and the load/debug port (requester 1). It grants at most one transaction per cycle, round-robin, with an optional short lock for read-modify-write sequences. It drives the register file enables and addresses and returns the read data as a tagged response one cycle later.

---
 rtl/rf_pkg.sv | 31 +++
 rtl/rr_lock_arbiter.sv | 74 +++++++
 rtl/regfile_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the register file arbiter
package rf_pkg;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 2;
  localparam int NUM_REG  = 1 << ADDR_W;
  localparam int MAX_LOCK = 4;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ren0;
    logic [ADDR_W-1:0] raddr0;
    logic              ren1;
    logic [ADDR_W-1:0] raddr1;
    logic              lock;
  } rf_req_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } rf_rsp_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - two-way round-robin grant with a bounded lock
// State advances on the falling clock edge, like the register file it serves.
module rr_lock_arbiter #(
  parameter int MAX_LOCK = rf_pkg::MAX_LOCK
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic [1:0] i_lock,
  output logic [1:0] o_grant
);
  import rf_pkg::*;

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  lock_state_e      r_state, w_next_state;
  logic             r_owner, w_next_owner;
  logic             r_last, w_next_last;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic [1:0]       w_grant;
  logic             w_win;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= UNLOCKED;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_last  <= w_next_last;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_grant      = 2'b00;
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_next_last  = r_last;
    w_next_cnt   = r_cnt;

    if (r_state == UNLOCKED) begin
      if (i_valid == 2'b11) w_grant = r_last ? 2'b01 : 2'b10;
      else                  w_grant = i_valid;
    end else if (i_valid[r_owner]) begin
      w_grant[r_owner] = 1'b1;
    end
    // No grant may escape while reset is held, even for a cycle.
    if (!i_rst_n) w_grant = 2'b00;

    w_win = w_grant[1];
    if (w_grant != 2'b00) begin
      w_next_last = w_win;
      if (r_state == UNLOCKED) begin
        if (i_lock[w_win] && MAX_LOCK > 1) begin
          w_next_state = LOCKED;
          w_next_owner = w_win;
          w_next_cnt   = CNT_W'(1);
        end
      end else if (!i_lock[w_win] || r_cnt == CNT_W'(MAX_LOCK - 1)) begin
        // The grant that brings the count to MAX_LOCK releases regardless of lock.
        w_next_state = UNLOCKED;
        w_next_cnt   = '0;
      end else begin
        w_next_cnt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - shares one register file between two requesters
// Optional write-through of same-transaction read/write: RF_ARB_BYPASS_EN.
module regfile_arbiter #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int MAX_LOCK = rf_pkg::MAX_LOCK
) (
  input  logic                CLKb,
  input  logic                RSTb,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_lock,
  input  logic [1:0]          req_wen,
  input  logic [1:0]          req_ren0,
  input  logic [1:0]          req_ren1,
  input  logic [2*ADDR_W-1:0] req_waddr,
  input  logic [2*ADDR_W-1:0] req_raddr0,
  input  logic [2*ADDR_W-1:0] req_raddr1,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0]   rf_D,
  output logic                rf_ENW,
  output logic                rf_ENR0,
  output logic                rf_ENR1,
  output logic [ADDR_W-1:0]   rf_WRA,
  output logic [ADDR_W-1:0]   rf_RDA0,
  output logic [ADDR_W-1:0]   rf_RDA1,
  input  logic [DATA_W-1:0]   rf_Q0,
  input  logic [DATA_W-1:0]   rf_Q1,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data0,
  output logic [DATA_W-1:0]   rsp_data1
);
  import rf_pkg::*;

  rf_req_t           w_req [2];
  rf_rsp_t           w_rsp;
  logic [1:0]        w_grant;
  logic              w_sel, w_xfer, w_rd;
  logic [DATA_W-1:0] w_data0, w_data1;
  logic              r_rsp_valid, r_rsp_id, r_ren0, r_ren1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_req[i].wen    = req_wen[i];
      w_req[i].waddr  = req_waddr[i*ADDR_W +: ADDR_W];
      w_req[i].wdata  = req_wdata[i*DATA_W +: DATA_W];
      w_req[i].ren0   = req_ren0[i];
      w_req[i].raddr0 = req_raddr0[i*ADDR_W +: ADDR_W];
      w_req[i].ren1   = req_ren1[i];
      w_req[i].raddr1 = req_raddr1[i*ADDR_W +: ADDR_W];
      w_req[i].lock   = req_lock[i];
    end
  end

  rr_lock_arbiter #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .i_clk   (CLKb),
    .i_rst_n (RSTb),
    .i_valid (req_valid),
    .i_lock  ({w_req[1].lock, w_req[0].lock}),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_sel     = w_grant[1];
  assign w_xfer    = |w_grant;

  assign rf_ENW  = w_xfer & w_req[w_sel].wen;
  assign rf_ENR0 = w_xfer & w_req[w_sel].ren0;
  assign rf_ENR1 = w_xfer & w_req[w_sel].ren1;
  assign rf_D    = w_xfer ? w_req[w_sel].wdata  : '0;
  assign rf_WRA  = w_xfer ? w_req[w_sel].waddr  : '0;
  assign rf_RDA0 = w_xfer ? w_req[w_sel].raddr0 : '0;
  assign rf_RDA1 = w_xfer ? w_req[w_sel].raddr1 : '0;
  assign w_rd    = rf_ENR0 | rf_ENR1;

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_ren0      <= 1'b0;
      r_ren1      <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd;
      r_ren0      <= rf_ENR0;
      r_ren1      <= rf_ENR1;
      if (w_rd) r_rsp_id <= w_sel;
    end
  end

`ifdef RF_ARB_BYPASS_EN
  logic              r_byp0, r_byp1;
  logic [DATA_W-1:0] r_byp_data0, r_byp_data1;

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_byp0      <= 1'b0;
      r_byp1      <= 1'b0;
      r_byp_data0 <= '0;
      r_byp_data1 <= '0;
    end else begin
      r_byp0      <= rf_ENW & rf_ENR0 & (rf_WRA == rf_RDA0);
      r_byp1      <= rf_ENW & rf_ENR1 & (rf_WRA == rf_RDA1);
      r_byp_data0 <= rf_D;
      r_byp_data1 <= rf_D;
    end
  end

  assign w_data0 = r_byp0 ? r_byp_data0 : rf_Q0;
  assign w_data1 = r_byp1 ? r_byp_data1 : rf_Q1;
`else
  assign w_data0 = rf_Q0;
  assign w_data1 = rf_Q1;
`endif

  // The register file holds Q between reads, so a port not read last cycle is masked.
  assign w_rsp.id    = r_rsp_id;
  assign w_rsp.data0 = r_ren0 ? w_data0 : '0;
  assign w_rsp.data1 = r_ren1 ? w_data1 : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = w_rsp.id;
  assign rsp_data0 = w_rsp.data0;
  assign rsp_data1 = w_rsp.data1;

endmodule
